// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared mode/state encodings and defaults for the VGA pattern controller
package vga_ctrl_pkg;

    localparam logic [1:0] MODE_VBAR  = 2'd0;
    localparam logic [1:0] MODE_HBAR  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    localparam int DEF_DB_CYCLES       = 1000000;
    localparam int DEF_FRAMES_PER_STEP = 120;
    localparam int DEF_NUM_MODES       = 4;

    typedef enum logic [1:0] {
        S_SHOW    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    function automatic logic [1:0] next_mode(input logic [1:0] cur, input int num_modes);
        return (cur == 2'(num_modes - 1)) ? MODE_VBAR : cur + 2'd1;
    endfunction

endpackage

// File: rtl/vga_pattern_ctrl_if.sv
// rtl/vga_pattern_ctrl_if.sv - board-input and generator-config signals of the pattern controller
interface vga_pattern_ctrl_if;
    logic       key_n;
    logic       auto_en;
    logic       vga_vs;
    logic       orient;
    logic [1:0] mode;
    logic       mode_chg;
    logic       pending;

    modport master (
        output key_n, auto_en, vga_vs,
        input  orient, mode, mode_chg, pending
    );

    modport slave (
        input  key_n, auto_en, vga_vs,
        output orient, mode, mode_chg, pending
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser, debounce counter and one-cycle press pulse
module key_debounce
    import vga_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          key_s1;
    logic          key_s2;
    logic          level;
    logic [CW-1:0] cnt;

    // level only flips after DB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 != level) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    level <= key_s2;
                    cnt   <= '0;
                    press <= ~key_s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/vga_pattern_ctrl.sv
// rtl/vga_pattern_ctrl.sv - steps the colour-bar display mode on key/auto requests at frame boundaries
module vga_pattern_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int DB_CYCLES       = DEF_DB_CYCLES,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int NUM_MODES       = DEF_NUM_MODES
) (
    input  logic              clk_50m,
    input  logic              reset,
    vga_pattern_ctrl_if.slave bus
);
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic          press;
    logic          auto_s1, auto_s2;
    logic          vs_s1, vs_s2, vs_d;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;
    logic          auto_req;
    logic          req;

    state_t        state, state_d;
    logic [1:0]    mode_q, mode_d;
    logic          chg_q, chg_d;
    logic          pend_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
        .clk   (clk_50m),
        .rst   (reset),
        .key_n (bus.key_n),
        .press (press)
    );

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_d    <= 1'b1;
        end else begin
            auto_s1 <= bus.auto_en;
            auto_s2 <= auto_s1;
            vs_s1   <= bus.vga_vs;
            vs_s2   <= vs_s1;
            vs_d    <= vs_s2;
        end
    end

    assign frame_start = vs_d & ~vs_s2;
    assign auto_req    = auto_s2 & frame_start & ~press &
                         (frame_cnt == FW'(FRAMES_PER_STEP - 1));
    assign req         = press | auto_req;

    // a manual press restarts the auto interval
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (!auto_s2 || press) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            if (frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        chg_d   = 1'b0;
        case (state)
            S_SHOW: begin
                if (req) begin
                    state_d = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                if (frame_start) begin
                    state_d = S_UPDATE;
                    mode_d  = next_mode(mode_q, NUM_MODES);
                    chg_d   = 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = req ? S_WAIT_VS : S_SHOW;
            end
            default: begin
                state_d = S_SHOW;
            end
        endcase
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state  <= S_SHOW;
            mode_q <= MODE_VBAR;
            chg_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            chg_q  <= chg_d;
            pend_q <= (state_d == S_WAIT_VS);
        end
    end

    assign bus.mode     = mode_q;
    assign bus.orient   = mode_q[0];
    assign bus.mode_chg = chg_q;
    assign bus.pending  = pend_q;
endmodule
